// File: rtl/cic_pkg.sv
// Shared widths for the CIC datapath and its post-decimation stages.
package cic_pkg;

  localparam int CIC_W         = 12;
  localparam int ACC_W         = 20;
  localparam int OUT_W         = 16;
  localparam int DECIM_DEFAULT = 32;

  localparam int FRAC_W = ACC_W - OUT_W;
  localparam int CALC_W = ACC_W + 2;

  // Clamp a wide intermediate to the ACC_W signed range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [CALC_W-1:0] v);
    logic [CALC_W-ACC_W:0] top;
    top = v[CALC_W-1:ACC_W-1];
    if ((&top) || (~|top)) begin
      return v[ACC_W-1:0];
    end else if (v[CALC_W-1]) begin
      return {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      return {1'b0, {(ACC_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is taken only
// when a pop frees a slot on the same edge.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

  // Head is forced to zero when empty so stale entries never leak out.
  assign rdata = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/cic_decim_hpf.sv
// Decimation stage behind a CIC moving sum: picks one sample per DECIM strobes,
// optionally removes DC with a one-pole blocker, and queues results for a consumer.
module cic_decim_hpf
  import cic_pkg::*;
#(
  parameter int DECIM      = DECIM_DEFAULT,
  parameter int HPF_K      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic signed [CIC_W-1:0] data_in,
  input  logic                    hpf_en,
  input  logic                    ovf_clr,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CNT_W-1:0]        cnt_reg;
  logic signed [CIC_W-1:0] x_reg;
  logic                    dec_stb_reg;
  logic signed [ACC_W-1:0] xs_prev_reg;
  logic signed [ACC_W-1:0] y_prev_reg;
  logic                    overflow_reg;

  logic signed [ACC_W-1:0]  xs;
  logic signed [CALC_W-1:0] xs_w;
  logic signed [CALC_W-1:0] xs_prev_w;
  logic signed [CALC_W-1:0] y_prev_w;
  logic signed [CALC_W-1:0] y_leak_w;
  logic signed [CALC_W-1:0] y_calc;
  logic signed [ACC_W-1:0]  y_next;

  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic [OUT_W-1:0] fifo_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      x_reg       <= '0;
      dec_stb_reg <= 1'b0;
    end else begin
      dec_stb_reg <= 1'b0;
      if (we) begin
        if (cnt_reg == CNT_W'(DECIM - 1)) begin
          cnt_reg     <= '0;
          x_reg       <= data_in;
          dec_stb_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign xs = {{(ACC_W-CIC_W-FRAC_W){x_reg[CIC_W-1]}}, x_reg, {FRAC_W{1'b0}}};

  always_comb begin
    xs_w      = xs;
    xs_prev_w = xs_prev_reg;
    y_prev_w  = y_prev_reg;
    y_leak_w  = y_prev_w >>> HPF_K;
    y_calc    = xs_w - xs_prev_w + y_prev_w - y_leak_w;
    y_next    = hpf_en ? sat_acc(y_calc) : xs;
  end

  // History tracks even in bypass, so switching the blocker on is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      xs_prev_reg <= '0;
      y_prev_reg  <= '0;
    end else if (dec_stb_reg) begin
      xs_prev_reg <= xs;
      y_prev_reg  <= y_next;
    end
  end

  sample_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dec_stb_reg),
    .pop   (out_ready),
    .wdata (y_next[ACC_W-1:FRAC_W]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign drop = dec_stb_reg && fifo_full && !(out_ready && !fifo_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_cic_decim_hpf.sv
// Directed bench for cic_decim_hpf: an integer/queue model checked every cycle,
// plus literal expectations on the popped sample stream.
module tb_cic_decim_hpf;

  localparam int DECIM = 32;
  localparam int K     = 6;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               we = 1'b0;
  logic signed [11:0] data_in = '0;
  logic               hpf_en = 1'b0;
  logic               ovf_clr = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               overflow;

  always #5 clk = ~clk;

  cic_decim_hpf #(
    .DECIM      (DECIM),
    .HPF_K      (K),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .data_in   (data_in),
    .hpf_en    (hpf_en),
    .ovf_clr   (ovf_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: count strobes, take every DECIM-th sample, filter with
  // integer arithmetic one edge later, and queue outputs.
  int  m_cnt = 0;
  bit  m_pend = 0;
  int  m_x = 0;
  int  m_xsp = 0;
  int  m_yp = 0;
  int  q[$];
  bit  m_ovf = 0;
  bit  started = 0;
  int  dut_log[$];

  always @(posedge clk) begin
    int  xs;
    int  y;
    bit  pop_now;
    bit  drop;
    if (!rst && out_valid === 1'b1 && out_ready) begin
      dut_log.push_back(int'(out_data));
      $display("POP data=%0d", out_data);
    end
    if (rst) begin
      m_cnt = 0; m_pend = 0; m_x = 0; m_xsp = 0; m_yp = 0; m_ovf = 0;
      q.delete();
    end else begin
      pop_now = out_ready && (q.size() > 0);
      if (pop_now) void'(q.pop_front());
      drop = 0;
      if (m_pend) begin
        xs = m_x * 16;
        if (hpf_en) begin
          y = xs - m_xsp + m_yp - (m_yp >>> K);
          if (y > 524287) y = 524287;
          if (y < -524288) y = -524288;
        end else begin
          y = xs;
        end
        m_xsp = xs;
        m_yp  = y;
        if (q.size() < DEPTH) q.push_back(y >>> 4);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_pend = 0;
      if (we) begin
        m_cnt++;
        if (m_cnt == DECIM) begin
          m_cnt  = 0;
          m_pend = 1;
          m_x    = int'(data_in);
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", out_valid, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      else chk("out_data_idle", out_data, 0);
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe; returns at the negedge right after the sampling edge.
  task automatic pulse(input logic signed [11:0] d);
    we = 1'b1;
    data_in = d;
    @(negedge clk);
    we = 1'b0;
    data_in = 12'sh5A5;
  endtask

  task automatic frame(input logic signed [11:0] d);
    repeat (DECIM - 1) pulse(12'($urandom));
    pulse(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    dut_log.delete();
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_count"}, dut_log.size(), exp.size());
    foreach (exp[i]) chk(name, (i < dut_log.size()) ? dut_log[i] : -99999, exp[i]);
    dut_log.delete();
  endtask

  initial begin
    cyc(3);
    chk("reset_valid", out_valid, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_data", out_data, 0);
    rst = 1'b0;

    // DC blocker settling on a constant input
    hpf_en = 1'b1;
    out_ready = 1'b1;
    repeat (3 * DECIM) pulse(12'sd100);
    cyc(4);
    chk_log("dc", '{100, 98, 96});

    // Reset mid-frame discards the partial frame
    repeat (20) pulse(12'sd7);
    rst = 1'b1;
    cyc(3);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_data", out_data, 0);
    rst = 1'b0;
    repeat (DECIM - 1) pulse(12'sd55);
    cyc(3);
    chk("midrst_early", out_valid, 0);
    pulse(12'sd55);
    chk("midrst_lat1", out_valid, 0);
    cyc(1);
    chk("midrst_lat2", out_valid, 1);
    cyc(2);
    chk_log("midrst", '{55});

    // Decimation with idle gaps between strobes
    do_reset();
    hpf_en = 1'b0;
    for (int i = 1; i <= 2 * DECIM; i++) begin
      pulse(12'(i));
      if (i % DECIM == 0) begin
        chk("gap_lat1", out_valid, 0);
        cyc(1);
        chk("gap_lat2", out_valid, 1);
      end
      cyc($urandom_range(0, 3));
    end
    cyc(3);
    chk_log("gap", '{32, 64});

    // Full-scale step through the blocker
    do_reset();
    hpf_en = 1'b1;
    frame(12'sd2047);
    frame(-12'sd2048);
    cyc(4);
    chk_log("step", '{2047, -2080});

    // Backpressure and sticky overflow
    do_reset();
    out_ready = 1'b0;
    hpf_en = 1'b0;
    for (int k = 1; k <= 5; k++) frame(12'(k));
    cyc(2);
    chk("bp_ovf", overflow, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("clr_alone", overflow, 0);
    frame(12'sd6);
    ovf_clr = 1'b1;
    cyc(1);
    chk("clr_vs_drop", overflow, 1);
    cyc(1);
    chk("clr_next", overflow, 0);
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    cyc(6);
    chk_log("drain", '{1, 2, 3, 4});
    chk("drain_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_decim_hpf.md
CIC_DECIM_HPF -- requirements
Module: cic_decim_hpf

Interface
REQ-001 SHALL have parameter DECIM, default 32: decimation ratio in input strobes, matching the CIC moving-sum length.
REQ-002 SHALL have parameter HPF_K, default 6: DC-blocker pole shift, a = 1 - 2^-HPF_K.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, a power of 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port we, input, 1 bit: input sample strobe, the same strobe that advances the upstream CIC.
REQ-007 SHALL have port data_in, input, signed 12 bits: CIC output, sampled only when we=1.
REQ-008 SHALL have port hpf_en, input, 1 bit: 1 applies the DC blocker; 0 passes samples through, scaled.
REQ-009 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-010 SHALL have port out_data, output, signed 16 bits: filtered sample, valid while out_valid=1.
REQ-011 SHALL have port out_valid, output, 1 bit: FIFO not empty.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accept; a pop occurs when out_valid and out_ready are both 1.
REQ-013 SHALL have port overflow, output, 1 bit: sticky; set when a sample is dropped.

Function
REQ-014 SHALL keep a phase counter cnt in 0..DECIM-1 that increments only on edges with we=1 and wraps from DECIM-1 to 0; we=0 holds cnt.
REQ-015 SHALL, on an edge with we=1 and cnt=DECIM-1, register x=data_in and assert an internal strobe dec_stb for exactly 1 cycle.
REQ-016 SHALL extend x internally to xs = sign-extended x << 4, a signed 20-bit value with 4 fractional bits.
REQ-017 SHALL, on the edge where dec_stb=1 and hpf_en=1, compute y = xs - xs_prev + y_prev - (y_prev >>> HPF_K) and then update xs_prev<=xs and y_prev<=y.
REQ-018 SHALL compute y from REQ-017 in at least 22-bit signed arithmetic and saturate it to the 20-bit signed range [-524288, 524287].
REQ-019 SHALL, when hpf_en=0, set y=xs; xs_prev and y_prev still update, so re-enabling causes no step transient.
REQ-020 SHALL push y[19:4] into the FIFO on the same edge as REQ-017, so out_valid rises 2 cycles after the decimating we edge when the FIFO was empty.
REQ-021 SHALL present the head entry on out_data, pop it on out_valid&&out_ready, and preserve FIFO order.
REQ-022 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle.
REQ-023 SHALL, on a push to a full FIFO with no pop, drop the new sample, keep the FIFO contents, and set overflow=1.
REQ-024 SHALL allow simultaneous push and pop on an empty FIFO: the pop is ignored because out_valid=0, and the push lands.
REQ-025 SHALL clear overflow when ovf_clr=1, except that a drop in the same cycle wins and overflow stays 1.
REQ-026 SHALL ignore data_in when we=0.

Reset
REQ-027 SHALL, while rst=1, clear cnt, x, dec_stb, xs_prev, y_prev and the FIFO pointers, and drive out_valid=0, out_data=0 and overflow=0.
REQ-028 SHALL, when reset is asserted mid-frame, discard the partial frame; the first output after reset is taken DECIM strobes after rst falls.

Structure
REQ-029 SHALL define constants CIC_W=12, ACC_W=20, OUT_W=16 and DECIM_DEFAULT=32 in shared package cic_pkg, also used by cic.
REQ-030 SHALL implement the FIFO as sub-module sample_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty); the rest of the block is flat.

Verification
REQ-031 SHALL cover reset: rst held 3 cycles mid-stream -> out_valid=0, overflow=0, out_data=0, and the next output comes only after 32 new we pulses.
REQ-032 SHALL cover the DC response: hpf_en=1, data_in=100 constant, 96 we pulses, out_ready=1 -> outputs 100, 98, 96 (y=1600, 1575, 1551).
REQ-033 SHALL cover decimation with gaps: 64 we pulses with random idle cycles between them -> exactly 2 outputs, each out_valid exactly 2 cycles after we pulse 32 and pulse 64.
REQ-034 SHALL cover backpressure: out_ready=0, hpf_en=0, data_in=1..5 at successive decimation points -> 4 entries held, overflow=1; draining yields 1, 2, 3, 4, then out_valid=0.
REQ-035 SHALL cover a large step: hpf_en=1, decimated inputs +2047 then -2048 -> outputs 2047 then -2080 (y=-33279), with no saturation.
REQ-036 SHALL cover ovf_clr: ovf_clr=1 in the same cycle as a drop -> overflow stays 1; ovf_clr=1 on the next cycle -> overflow=0.
